// File: rtl/ram2e_pkg.sv
// Shared constants for the RAM2E DRAM scheduler: state numbers of the
// 14-cycle PHI frame and the refresh credit width.
package ram2e_pkg;

    localparam int unsigned S_W      = 4;
    localparam int unsigned BANK_W   = 6;
    localparam int unsigned RA_W     = 4;
    localparam int unsigned CREDIT_W = 3;
    localparam int unsigned TIMER_W  = 4;

    localparam logic [S_W-1:0] ST_IDLE       = 4'd0;
    localparam logic [S_W-1:0] VID_RAS       = 4'd1;
    localparam logic [S_W-1:0] VID_CAS       = 4'd2;
    localparam logic [S_W-1:0] VID_LE        = 4'd3;
    localparam logic [S_W-1:0] REF           = 4'd5;
    localparam logic [S_W-1:0] CPU_ROW       = 4'd6;
    localparam logic [S_W-1:0] CPU_RAS_START = 4'd7;
    localparam logic [S_W-1:0] CPU_COL       = 4'd8;
    localparam logic [S_W-1:0] CPU_CAS_RD    = 4'd9;
    localparam logic [S_W-1:0] CPU_RAS_END   = 4'd11;
    localparam logic [S_W-1:0] CAS_OFF       = 4'd12;
    localparam logic [S_W-1:0] BANK_WR       = 4'd13;
    localparam logic [S_W-1:0] PARK          = 4'd15;

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = 3'd7;

endpackage

// File: rtl/ram2e_refresh_timer.sv
// Refresh pacing: one credit every REF_INTERVAL sync events, consumed by
// RAS-only refresh grants; saturating count with a sticky overflow flag.
module ram2e_refresh_timer
    import ram2e_pkg::*;
#(
    parameter int unsigned REF_INTERVAL = 13
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sync,
    input  logic                grant,
    input  logic                ref_en,
    output logic [CREDIT_W-1:0] owed,
    output logic                ovf
);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REF_INTERVAL - 1);

    logic [TIMER_W-1:0] timer;
    logic               add_c;
    logic               take_c;

    assign add_c  = sync & (timer == TIMER_LAST);
    assign take_c = grant & ref_en & (owed != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
            owed  <= '0;
            ovf   <= 1'b0;
        end else begin
            if (sync) begin
                timer <= add_c ? '0 : timer + TIMER_W'(1);
            end
            // Add and take together cancel out.
            case ({add_c, take_c})
                2'b10: begin
                    if (owed == CREDIT_MAX) begin
                        ovf <= 1'b1;
                    end else begin
                        owed <= owed + CREDIT_W'(1);
                    end
                end
                2'b01:   owed <= owed - CREDIT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ram2e_dram_sched.sv
// RAM2E DRAM scheduler: locks a 4-bit state counter to the Apple II PHI
// clock and sequences video, refresh and CPU DRAM cycles plus the bank register.
module ram2e_dram_sched
    import ram2e_pkg::*;
#(
    parameter int unsigned REF_INTERVAL = 13
) (
    input  logic                C14M,
    input  logic                nRST,
    input  logic                PHI1,
    input  logic                nWE80,
    input  logic                ref_en,
    input  logic                bank_wr_valid,
    input  logic [BANK_W-1:0]   bank_wr_data,
    output logic                bank_wr_ready,
    output logic                nRAS,
    output logic                nCAS,
    output logic [RA_W-1:0]     RA,
    output logic [S_W-1:0]      S,
    output logic                vd_le,
    output logic [CREDIT_W-1:0] ref_owed,
    output logic                ref_ovf,
    output logic                sync_lost
);

    logic              phi1_reg;
    logic              phi0_seen;
    logic              sync;
    logic              grant;
    logic [S_W-1:0]    s_next;
    logic [BANK_W-1:0] bank;
    logic              ras_c;
    logic              cas_high_c;
    logic              cas_low_c;
    logic              bank_ld_c;
    logic [RA_W-1:0]   ra_c;
    logic              unused_bank;

    assign sync        = PHI1 & ~phi1_reg & phi0_seen;
    assign grant       = (S == REF) & ref_en & (ref_owed != '0);
    assign unused_bank = bank[BANK_W-1];

    // Next state: resync on PHI rising edge, otherwise count until parked.
    always_comb begin
        s_next = S;
        if (sync) begin
            s_next = VID_RAS;
        end else if ((S != ST_IDLE) && (S != PARK)) begin
            s_next = S + S_W'(1);
        end
    end

    // Strobe and address decode; RA and the bank strobe follow the next state
    // so they line up with the S value they belong to.
    always_comb begin
        ras_c      = sync | (S == VID_RAS) | (S == VID_CAS) | grant
                   | ((S >= CPU_RAS_START) && (S <= CPU_RAS_END));
        cas_high_c = (S == ST_IDLE) | (S == VID_LE) | (S == CAS_OFF);
        cas_low_c  = (S == VID_CAS) | ((S == CPU_CAS_RD) & nWE80)
                   | ((S == CPU_RAS_END) & ~nWE80);
        bank_ld_c  = bank_wr_valid & (s_next == BANK_WR);
        ra_c       = '0;
        if ((s_next == CPU_ROW) || (s_next == CPU_RAS_START)) begin
            ra_c = {1'b0, bank[4:2]};
        end else if ((s_next >= CPU_COL) && (s_next <= CPU_RAS_END)) begin
            ra_c = {2'b00, bank[1:0]};
        end
    end

    always_ff @(posedge C14M or negedge nRST) begin
        if (!nRST) begin
            phi1_reg      <= 1'b0;
            phi0_seen     <= 1'b0;
            S             <= ST_IDLE;
            nRAS          <= 1'b1;
            nCAS          <= 1'b1;
            RA            <= '0;
            vd_le         <= 1'b0;
            sync_lost     <= 1'b0;
            bank          <= '0;
            bank_wr_ready <= 1'b0;
        end else begin
            phi1_reg <= PHI1;
            if (!PHI1) begin
                phi0_seen <= 1'b1;
            end
            S         <= s_next;
            nRAS      <= ~ras_c;
            // Set-high wins over a coincident drive-low.
            if (cas_high_c) begin
                nCAS <= 1'b1;
            end else if (cas_low_c) begin
                nCAS <= 1'b0;
            end
            RA            <= ra_c;
            vd_le         <= (S == VID_LE);
            sync_lost     <= (s_next == PARK);
            bank_wr_ready <= bank_ld_c;
            if (bank_ld_c) begin
                bank <= bank_wr_data;
            end
        end
    end

    ram2e_refresh_timer #(
        .REF_INTERVAL(REF_INTERVAL)
    ) u_refresh (
        .clk   (C14M),
        .rst_n (nRST),
        .sync  (sync),
        .grant (grant),
        .ref_en(ref_en),
        .owed  (ref_owed),
        .ovf   (ref_ovf)
    );

endmodule
